// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch stage and the load/store unit: fetch state
// encoding, instruction size and the address-legality check.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Word-aligned and below the exclusive limit. Callers widen to 64 bits.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load beats increment, increment wraps modulo 2^ADDR_W.
// Updates are taken only while en_i is high.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i && load_i)     pc_d = target_i;
    else if (en_i && inc_i) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, req/ack handshake with instruction memory,
// wait/fault flags for the control FSM. Optional ack watchdog: INSTR_FETCH_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = 32'h0001_0000,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              wait_instr,
  output logic              instr_segv
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT must be non-zero");
  end

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              segv_q, segv_d;
  logic              pc_legal;

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == FETCH_IDLE),
    .load_i  (pc_load),
    .inc_i   (pc_inc),
    .target_i(pc_target),
    .pc_o    (pc)
  );

  assign pc_legal = addr_legal(64'(pc), 64'(MEM_LIMIT));

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    instr_d   = instr_q;
    segv_d    = segv_q;
`ifdef INSTR_FETCH_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      FETCH_IDLE: begin
        if (fetch_start) begin
          if (pc_legal) begin
            state_d   = FETCH_REQ;
            mem_req_d = 1'b1;
`ifdef INSTR_FETCH_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end else begin
            state_d = FETCH_DONE;
            segv_d  = 1'b1;
            instr_d = '0;
          end
        end
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          state_d   = FETCH_DONE;
          mem_req_d = 1'b0;
          instr_d   = mem_rdata;
          segv_d    = 1'b0;
        end
`ifdef INSTR_FETCH_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d   = FETCH_DONE;
          mem_req_d = 1'b0;
          instr_d   = '0;
          segv_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      FETCH_DONE: begin
        if (!fetch_start) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH_IDLE;
      mem_req_q <= 1'b0;
      instr_q   <= '0;
      segv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      instr_q   <= instr_d;
      segv_q    <= segv_d;
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign mem_req    = mem_req_q;
  assign mem_addr   = pc;
  assign instr      = instr_q;
  assign instr_segv = segv_q;
  assign wait_instr = fetch_start && (state_q != FETCH_DONE);

  // The PC only moves in IDLE; strobes elsewhere are a control-path bug.
  a_pc_update_idle : assert property (@(posedge clk) disable iff (reset)
    (pc_load || pc_inc) |-> (state_q == FETCH_IDLE));

endmodule
